// File: rtl/taxi_eth_link_ctrl_pkg.sv
// Shared types for the 10G link supervisor: state encoding, cfg field widths, timer width.
package taxi_eth_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERDES_RST  = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STATUS = 3'd3,
    ST_UP          = 3'd4,
    ST_HOLDOFF     = 3'd5,
    ST_PRBS        = 3'd6
  } link_state_t;

  localparam int CFG_LEN_W = 16;
  localparam int CFG_IFG_W = 8;
  localparam int TIMER_W   = 32;

endpackage

// File: rtl/taxi_eth_link_timer.sv
// Clearable saturating up-counter; tc flags the last cycle of a limit-cycle dwell.
module taxi_eth_link_timer
  import taxi_eth_link_ctrl_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count starts at 0 on entry, so limit-1 is the final cycle of the dwell.
  assign tc = (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/taxi_eth_mac_10g_link_ctrl.sv
// 10G link bring-up/supervision FSM. Optional PRBS31 test mode under TAXI_ETH_LINK_CTRL_PRBS_EN.
module taxi_eth_mac_10g_link_ctrl
  import taxi_eth_link_ctrl_pkg::*;
#(
  parameter int SERDES_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT      = 65536,
  parameter int STATUS_TIMEOUT    = 65536,
  parameter int DEBOUNCE_CYCLES   = 1024,
  parameter int HOLDOFF_CYCLES    = 4096,
  parameter int MAX_PKT_LEN       = 1518,
  parameter int IFG               = 12,
  parameter int CNT_W             = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 rx_block_lock,
  input  logic                 rx_high_ber,
  input  logic                 rx_status,
  input  logic                 serdes_rx_reset_req,
`ifdef TAXI_ETH_LINK_CTRL_PRBS_EN
  input  logic                 prbs_req,
  output logic                 cfg_tx_prbs31_enable,
  output logic                 cfg_rx_prbs31_enable,
`endif
  output logic                 serdes_rst,
  output logic                 cfg_tx_enable,
  output logic                 cfg_rx_enable,
  output logic [CFG_LEN_W-1:0] cfg_tx_max_pkt_len,
  output logic [CFG_LEN_W-1:0] cfg_rx_max_pkt_len,
  output logic [CFG_IFG_W-1:0] cfg_tx_ifg,
  output logic                 link_up,
  output logic [2:0]           link_state,
  output logic [CNT_W-1:0]     flap_count,
  output logic [CNT_W-1:0]     timeout_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  link_state_t        state_q, state_d;
  logic               enter, timeout, flap, loss, tc, prbs_req_i;
  logic [TIMER_W-1:0] limit;
  logic [TIMER_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]   flap_q, flap_d, tout_q, tout_d;
  logic               srst_q, srst_d, rx_en_q, rx_en_d;
  logic               tx_en_q, tx_en_d, link_up_q, link_up_d;

`ifdef TAXI_ETH_LINK_CTRL_PRBS_EN
  logic prbs_en_q, prbs_en_d;
  assign prbs_req_i = prbs_req;
`else
  assign prbs_req_i = 1'b0;
`endif

  assign loss = !rx_status || rx_high_ber || !rx_block_lock;

  taxi_eth_link_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (enter),
    .limit(limit),
    .tc   (tc)
  );

  always_comb begin
    limit = '0;
    case (state_q)
      ST_SERDES_RST:  limit = TIMER_W'(SERDES_RST_CYCLES);
      ST_WAIT_LOCK:   limit = TIMER_W'(LOCK_TIMEOUT);
      ST_WAIT_STATUS: limit = TIMER_W'(STATUS_TIMEOUT);
      ST_HOLDOFF:     limit = TIMER_W'(HOLDOFF_CYCLES);
      default:        limit = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    timeout = 1'b0;
    flap    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (serdes_rx_reset_req && (state_q != ST_IDLE)) begin
      // Forced re-entry: restarts the reset pulse even if already in SERDES_RST.
      state_d = ST_SERDES_RST;
      enter   = 1'b1;
      flap    = (state_q == ST_UP) && loss;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SERDES_RST;
        ST_SERDES_RST: if (tc) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (prbs_req_i) begin
            state_d = ST_PRBS;
          end else if (rx_block_lock && !rx_high_ber) begin
            state_d = ST_WAIT_STATUS;
          end else if (tc) begin
            state_d = ST_SERDES_RST;
            timeout = 1'b1;
          end
        end
        ST_WAIT_STATUS: begin
          if (!rx_block_lock || rx_high_ber) begin
            state_d = ST_WAIT_LOCK;
          end else if (rx_status && (deb_q == TIMER_W'(DEBOUNCE_CYCLES - 1))) begin
            state_d = ST_UP;
          end else if (tc) begin
            state_d = ST_SERDES_RST;
            timeout = 1'b1;
          end
        end
        ST_UP: begin
          if (prbs_req_i) begin
            state_d = ST_PRBS;
          end else if (loss) begin
            state_d = ST_HOLDOFF;
            flap    = 1'b1;
          end
        end
        ST_HOLDOFF: if (tc) state_d = ST_WAIT_LOCK;
        ST_PRBS: if (!prbs_req_i) state_d = ST_SERDES_RST;
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d != state_q) enter = 1'b1;
  end

  always_comb begin
    deb_d = '0;
    if (!enter && (state_q == ST_WAIT_STATUS) && rx_status) begin
      deb_d = deb_q + TIMER_W'(1);
    end
    flap_d    = flap ? sat_inc(flap_q) : flap_q;
    tout_d    = timeout ? sat_inc(tout_q) : tout_q;
    srst_d    = (state_d == ST_SERDES_RST);
    rx_en_d   = (state_d == ST_UP);
    // TX follows RX by one cycle on entry to UP.
    tx_en_d   = (state_d == ST_UP) && (state_q == ST_UP);
    link_up_d = (state_d == ST_UP);
`ifdef TAXI_ETH_LINK_CTRL_PRBS_EN
    prbs_en_d = (state_d == ST_PRBS);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      deb_q     <= '0;
      flap_q    <= '0;
      tout_q    <= '0;
      srst_q    <= 1'b0;
      rx_en_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      link_up_q <= 1'b0;
`ifdef TAXI_ETH_LINK_CTRL_PRBS_EN
      prbs_en_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      flap_q    <= flap_d;
      tout_q    <= tout_d;
      srst_q    <= srst_d;
      rx_en_q   <= rx_en_d;
      tx_en_q   <= tx_en_d;
      link_up_q <= link_up_d;
`ifdef TAXI_ETH_LINK_CTRL_PRBS_EN
      prbs_en_q <= prbs_en_d;
`endif
    end
  end

  assign serdes_rst         = srst_q;
  assign cfg_rx_enable      = rx_en_q;
  assign cfg_tx_enable      = tx_en_q;
  assign link_up            = link_up_q;
  assign link_state         = state_q;
  assign flap_count         = flap_q;
  assign timeout_count      = tout_q;
  assign cfg_tx_max_pkt_len = CFG_LEN_W'(MAX_PKT_LEN);
  assign cfg_rx_max_pkt_len = CFG_LEN_W'(MAX_PKT_LEN);
  assign cfg_tx_ifg         = CFG_IFG_W'(IFG);
`ifdef TAXI_ETH_LINK_CTRL_PRBS_EN
  assign cfg_tx_prbs31_enable = prbs_en_q;
  assign cfg_rx_prbs31_enable = prbs_en_q;
`endif

endmodule
